// File: rtl/sigmoid_grad_unit.sv
// Sigmoid backward-pass unit: delta = err * a * (1 - a) in signed fixed point,
// two-stage valid/ready pipeline with a delivered-result counter.
module sigmoid_grad_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC       = (DATA_WIDTH + 1) / 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] act,
    input  logic signed [DATA_WIDTH-1:0] err,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] delta,
    output logic        [CNT_WIDTH-1:0]  count
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [PW-1:0] ONE = PW'(2 ** FRAC);

    logic                         r_v1;
    logic                         r_v2;
    logic signed [DATA_WIDTH-1:0] r_p;
    logic signed [DATA_WIDTH-1:0] r_err1;
    logic signed [DATA_WIDTH-1:0] r_delta;
    logic        [CNT_WIDTH-1:0]  r_count;

    logic                         w_stage2_free;
    logic                         w_move;
    logic                         w_accept;
    logic signed [PW-1:0]         w_act_ext;
    logic signed [PW-1:0]         w_a_c;
    logic signed [PW-1:0]         w_prod1;
    logic signed [DATA_WIDTH-1:0] w_p;
    logic signed [PW-1:0]         w_err_ext;
    logic signed [PW-1:0]         w_p_ext;
    logic signed [PW-1:0]         w_prod2;
    logic signed [DATA_WIDTH-1:0] w_delta_nx;

    assign w_stage2_free = !r_v2 || out_ready;
    assign w_move        = r_v1 && w_stage2_free;
    assign in_ready      = !r_v1 || w_stage2_free;
    assign w_accept      = in_valid && in_ready;

    // Clamp the activation into [0, ONE] before forming a*(1-a)
    assign w_act_ext = {{DATA_WIDTH{act[DATA_WIDTH-1]}}, act};
    always_comb begin
        w_a_c = w_act_ext;
        if (act[DATA_WIDTH-1]) begin
            w_a_c = '0;
        end else if (w_act_ext > ONE) begin
            w_a_c = ONE;
        end
    end

    assign w_prod1 = w_a_c * (ONE - w_a_c);
    assign w_p     = DATA_WIDTH'(w_prod1 >>> FRAC);

    // |err * p| >> FRAC never exceeds |err|/4, so plain truncation is safe
    assign w_err_ext  = {{DATA_WIDTH{r_err1[DATA_WIDTH-1]}}, r_err1};
    assign w_p_ext    = {{DATA_WIDTH{r_p[DATA_WIDTH-1]}}, r_p};
    assign w_prod2    = w_err_ext * w_p_ext;
    assign w_delta_nx = DATA_WIDTH'(w_prod2 >>> FRAC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_p     <= '0;
            r_err1  <= '0;
            r_delta <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_v1   <= 1'b1;
                r_p    <= w_p;
                r_err1 <= err;
            end else if (w_move) begin
                r_v1 <= 1'b0;
            end

            if (w_move) begin
                r_v2    <= 1'b1;
                r_delta <= w_delta_nx;
            end else if (out_ready) begin
                r_v2 <= 1'b0;
            end

            if (r_v2 && out_ready) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    assign out_valid = r_v2;
    assign delta     = r_delta;
    assign count     = r_count;

endmodule

// File: tb/tb_sigmoid_grad_unit.sv
// Directed self-checking bench for sigmoid_grad_unit: table vectors plus
// hand-written backpressure, reset and counter-wrap sequences.
module tb_sigmoid_grad_unit;

    typedef struct {
        logic signed [7:0] act;
        logic signed [7:0] err;
        logic signed [7:0] exp;
    } vec_t;

    localparam int NV = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] act = '0;
    logic signed [7:0] err = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic signed [7:0] delta;
    logic [15:0]       count;

    logic              in_valid2 = 1'b0;
    logic              in_ready2;
    logic signed [7:0] act2 = '0;
    logic signed [7:0] err2 = '0;
    logic              out_valid2;
    logic signed [7:0] delta2;
    logic [1:0]        count2;

    int n_vec  = 0;
    int n_fail = 0;
    vec_t tbl [NV];
    int wrap_exp [5];

    always #5 clk = ~clk;

    sigmoid_grad_unit #(.DATA_WIDTH(8), .FRAC(4), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .act(act), .err(err), .out_valid(out_valid), .out_ready(out_ready),
        .delta(delta), .count(count)
    );

    sigmoid_grad_unit #(.DATA_WIDTH(8), .FRAC(4), .CNT_WIDTH(2)) u_dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .act(act2), .err(err2), .out_valid(out_valid2), .out_ready(1'b1),
        .delta(delta2), .count(count2)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{8'sd8,    8'sd16,   8'sd4};
        tbl[1]  = '{8'sd16,   8'sd50,   8'sd0};
        tbl[2]  = '{-8'sd3,   8'sd50,   8'sd0};
        tbl[3]  = '{8'sd20,   -8'sd7,   8'sd0};
        tbl[4]  = '{8'sd0,    8'sd127,  8'sd0};
        tbl[5]  = '{8'sd4,    -8'sd5,   -8'sd1};
        tbl[6]  = '{8'sd4,    8'sd5,    8'sd0};
        tbl[7]  = '{8'sd8,    -8'sd128, -8'sd32};
        tbl[8]  = '{8'sd8,    8'sd127,  8'sd31};
        tbl[9]  = '{8'sd12,   -8'sd100, -8'sd19};
        tbl[10] = '{8'sd2,    8'sd127,  8'sd7};
        tbl[11] = '{8'sd6,    -8'sd64,  -8'sd12};
        tbl[12] = '{8'sd127,  8'sd1,    8'sd0};
        tbl[13] = '{-8'sd128, -8'sd128, 8'sd0};
        wrap_exp = '{1, 2, 3, 0, 1};

        // Reset state
        #2;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_delta", int'(delta), 0);
        check("reset_count", int'(count), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 1);

        // One isolated sample per vector: latency, value and count
        for (int i = 0; i < NV; i++) begin
            act = tbl[i].act;
            err = tbl[i].err;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("lat_v%0d_early", i), int'(out_valid), 0);
            @(negedge clk);
            check($sformatf("lat_v%0d_valid", i), int'(out_valid), 1);
            check($sformatf("lat_v%0d_delta", i), int'(delta), int'(tbl[i].exp));
            @(negedge clk);
            check($sformatf("lat_v%0d_count", i), int'(count), i + 1);
        end

        // Full-rate stream of the whole table
        do_reset();
        for (int cyc = 0; cyc < NV + 3; cyc++) begin
            if (cyc >= 2 && cyc < NV + 2) begin
                check($sformatf("stream_valid%0d", cyc - 2), int'(out_valid), 1);
                check($sformatf("stream_delta%0d", cyc - 2), int'(delta), int'(tbl[cyc - 2].exp));
            end
            if (cyc < NV) begin
                check($sformatf("stream_in_ready%0d", cyc), int'(in_ready), 1);
                act = tbl[cyc].act;
                err = tbl[cyc].err;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("stream_drained", int'(out_valid), 0);
        check("stream_count", int'(count), NV);

        // Backpressure: two samples buffered, third stalled
        do_reset();
        out_ready = 1'b0;
        act = 8'sd8;
        err = 8'sd16;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_ready_after1", int'(in_ready), 1);
        err = 8'sd32;
        @(negedge clk);
        err = 8'sd48;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_stall_ready%0d", k), int'(in_ready), 0);
            check($sformatf("bp_hold_valid%0d", k), int'(out_valid), 1);
            check($sformatf("bp_hold_delta%0d", k), int'(delta), 4);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_release", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_out2_valid", int'(out_valid), 1);
        check("bp_out2_delta", int'(delta), 8);
        @(negedge clk);
        check("bp_out3_valid", int'(out_valid), 1);
        check("bp_out3_delta", int'(delta), 12);
        @(negedge clk);
        check("bp_drained", int'(out_valid), 0);
        check("bp_count", int'(count), 3);

        // Asynchronous reset with both stages occupied
        do_reset();
        act = 8'sd8;
        err = 8'sd16;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_count", int'(count), 1);
        out_ready = 1'b0;
        act = 8'sd8;
        err = 8'sd127;
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_pre_full", int'(in_ready), 0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", int'(out_valid), 0);
        check("rst_async_delta", int'(delta), 0);
        check("rst_async_count", int'(count), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        check("rst_post_idle", int'(out_valid), 0);
        act = 8'sd8;
        err = 8'sd16;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_post_early", int'(out_valid), 0);
        @(negedge clk);
        check("rst_post_valid", int'(out_valid), 1);
        check("rst_post_delta", int'(delta), 4);
        @(negedge clk);
        check("rst_post_count", int'(count), 1);

        // Counter wrap on the 2-bit instance
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc >= 3) begin
                check($sformatf("wrap_count%0d", cyc - 3), int'(count2), wrap_exp[cyc - 3]);
            end
            if (cyc < 5) begin
                act2 = 8'sd8;
                err2 = 8'sd16;
                in_valid2 = 1'b1;
            end else begin
                in_valid2 = 1'b0;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
